// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle accumulator core: opcodes, FSM states,
// ALU operations and the instruction-class decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluOr,
        AluNand,
        AluShl,
        AluShr
    } alu_op_e;

    typedef enum logic [2:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsHalt,
        ClsNop
    } instr_cls_e;

    localparam logic [3:0] OpLoad  = 4'b0000;
    localparam logic [3:0] OpStore = 4'b0010;
    localparam logic [3:0] OpAdd   = 4'b0100;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpNand  = 4'b1000;
    localparam logic [3:0] OpJ     = 4'b0001;
    localparam logic [3:0] OpBnz   = 4'b0101;
    localparam logic [3:0] OpBpz   = 4'b1001;
    localparam logic [3:0] OpBz    = 4'b1010;
    localparam logic [3:0] OpHalt  = 4'b1100;
    localparam logic [2:0] OpOriLow   = 3'b111;
    localparam logic [2:0] OpShiftLow = 3'b011;

    // ORi and SHIFT are matched on the low three bits before the full opcode.
    function automatic instr_cls_e decode_cls(input logic [3:0] op);
        instr_cls_e cls;
        if (op[2:0] == OpOriLow || op[2:0] == OpShiftLow) begin
            cls = ClsAlu;
        end else begin
            case (op)
                OpLoad:                   cls = ClsLoad;
                OpStore:                  cls = ClsStore;
                OpAdd, OpSub, OpNand:     cls = ClsAlu;
                OpJ, OpBnz, OpBpz, OpBz:  cls = ClsBranch;
                OpHalt:                   cls = ClsHalt;
                default:                  cls = ClsNop;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multicycle core with negative/zero result flags.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  alu_op_e           op_i,
    input  logic [1:0]        shamt_i,
    output logic [DATA_W-1:0] res_o,
    output logic              n_o,
    output logic              z_o
);

    always_comb begin
        res_o = '0;
        case (op_i)
            AluAdd:  res_o = a_i + b_i;
            AluSub:  res_o = a_i - b_i;
            AluOr:   res_o = a_i | b_i;
            AluNand: res_o = ~(a_i & b_i);
            AluShl:  res_o = a_i << shamt_i;
            AluShr:  res_o = a_i >> shamt_i;
            default: res_o = '0;
        endcase
    end

    assign n_o = res_o[DATA_W-1];
    assign z_o = (res_o == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle accumulator-style core: 4-entry register file, control FSM and
// datapath registers around a req/ready memory port with run/step control.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              CLOCK_50,
    input  logic              RESETn,
    input  logic              run,
    input  logic              step,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        ir,
    output logic [2:0]        state,
    output logic              flag_n,
    output logic              flag_z,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic              flag_n_q, flag_n_d, flag_z_q, flag_z_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    instr_cls_e        cls;
    logic              is_ori, taken, retire;
    logic [1:0]        dest;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_b, alu_res;
    logic              alu_n, alu_z;

    assign cls    = decode_cls(ir_q[3:0]);
    assign is_ori = (ir_q[2:0] == OpOriLow);
    assign dest   = is_ori ? 2'd1 : ir_q[7:6];

    always_comb begin
        alu_op = AluAdd;
        alu_b  = b_q;
        if (is_ori) begin
            alu_op = AluOr;
            alu_b  = DATA_W'(ir_q[7:3]);
        end else if (ir_q[2:0] == OpShiftLow) begin
            alu_op = ir_q[5] ? AluShl : AluShr;
        end else begin
            case (ir_q[3:0])
                OpSub:   alu_op = AluSub;
                OpNand:  alu_op = AluNand;
                default: alu_op = AluAdd;
            endcase
        end
    end

    always_comb begin
        case (ir_q[3:0])
            OpJ:     taken = 1'b1;
            OpBnz:   taken = !flag_z_q;
            OpBpz:   taken = !flag_n_q;
            OpBz:    taken = flag_z_q;
            default: taken = 1'b0;
        endcase
    end

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i     (a_q),
        .b_i     (alu_b),
        .op_i    (alu_op),
        .shamt_i (ir_q[4:3]),
        .res_o   (alu_res),
        .n_o     (alu_n),
        .z_o     (alu_z)
    );

    // FSM: state register
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (run || step) state_d = StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec: begin
                case (cls)
                    ClsAlu:   state_d = StWb;
                    ClsLoad:  if (mem_ready) state_d = StWb;
                    ClsStore: if (mem_ready) state_d = run ? StFetch : StIdle;
                    ClsHalt:  state_d = StHalt;
                    default:  state_d = run ? StFetch : StIdle;
                endcase
            end
            StWb:     state_d = run ? StFetch : StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        retire    = 1'b0;
        if (state_q == StFetch) begin
            mem_req = 1'b1;
        end else if (state_q == StExec) begin
            case (cls)
                ClsLoad: begin
                    mem_req  = 1'b1;
                    mem_addr = b_q[ADDR_W-1:0];
                end
                ClsStore: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = b_q[ADDR_W-1:0];
                    mem_wdata = a_q;
                    retire    = mem_ready;
                end
                ClsAlu:  retire = 1'b0;
                default: retire = 1'b1;
            endcase
        end else if (state_q == StWb) begin
            retire = 1'b1;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        regs_d   = regs_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        cnt_d    = cnt_q + CNT_W'(retire);
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d = mem_rdata[7:0];
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            StDecode: begin
                a_d = regs_q[dest];
                b_d = regs_q[ir_q[5:4]];
            end
            StExec: begin
                case (cls)
                    ClsAlu: begin
                        alu_d    = alu_res;
                        flag_n_d = alu_n;
                        flag_z_d = alu_z;
                    end
                    ClsLoad:   if (mem_ready) mdr_d = mem_rdata;
                    // Offset is relative to the already-incremented PC.
                    ClsBranch: if (taken) pc_d = pc_q + {{(ADDR_W-4){ir_q[7]}}, ir_q[7:4]};
                    default:   ;
                endcase
            end
            StWb:    regs_d[dest] = (cls == ClsLoad) ? mdr_q : alu_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            regs_q   <= regs_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign state       = state_q;
    assign flag_n      = flag_n_q;
    assign flag_z      = flag_z_q;
    assign halted      = (state_q == StHalt);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: store transactions are checked by a scoreboard
// monitor, status/timing by fixed-cycle probes after each program.
module tb_multicycle_cpu;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          run   = 1'b0;
    logic          step  = 1'b0;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr, pc;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    ir;
    logic [2:0]    state;
    logic          flag_n, flag_z, halted;
    logic [CW-1:0] instr_count;

    logic [DW-1:0] mem [256];
    int unsigned   waits = 0;
    int unsigned   wcnt  = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    wr_t           exp_q [$];

    multicycle_cpu #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RESET_PC (8'h00),
        .CNT_W    (CW)
    ) u_dut (
        .CLOCK_50    (clk),
        .RESETn      (rst_n),
        .run         (run),
        .step        (step),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .pc          (pc),
        .ir          (ir),
        .state       (state),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: ready rises after `waits` stall cycles of a held request.
    initial mem_ready = 1'b0;
    always @(negedge clk) begin
        if (mem_req && wcnt == waits) begin
            mem_ready <= 1'b1;
            wcnt      <= 0;
        end else begin
            mem_ready <= 1'b0;
            wcnt      <= mem_req ? wcnt + 1 : 0;
        end
    end

    // Monitor: pops expected stores and checks request stability during stalls.
    logic          stall_q = 1'b0;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [DW-1:0] s_wdata;
    always @(posedge clk) begin
        wr_t e;
        if (stall_q && mem_req) begin
            check("stall_addr", 32'(mem_addr), 32'(s_addr));
            check("stall_we", 32'(mem_we), 32'(s_we));
            check("stall_wdata", 32'(mem_wdata), 32'(s_wdata));
        end
        stall_q <= mem_req && !mem_ready;
        s_addr  <= mem_addr;
        s_we    <= mem_we;
        s_wdata <= mem_wdata;
        if (mem_req && mem_ready && mem_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("store_addr", 32'(mem_addr), 32'(e.addr));
                check("store_data", 32'(mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold reset, clear memory to HALT so a runaway program stops.
    task automatic hold_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 16'h000C;
    endtask

    task automatic release_reset(input int unsigned w, input logic r);
        waits = w;
        run   = r;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        hold_reset();
        #1;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_state", 32'(state), 32'h0);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(instr_count), 32'h0);
        check("rst_flags", 32'({flag_n, flag_z}), 32'h0);

        // ORi 5 ; ADD R1,R1 ; STORE R1 -> [R0] ; HALT, zero wait states
        hold_reset();
        mem[0] = 16'h002F; mem[1] = 16'h0054; mem[2] = 16'h0042; mem[3] = 16'h000C;
        exp_q.push_back('{addr: 8'h00, data: 16'h000A});
        release_reset(0, 1'b1);
        tick(14);
        check("t1_halted_e14", 32'(halted), 32'h0);
        tick(1);
        check("t1_halted_e15", 32'(halted), 32'h1);
        check("t1_state", 32'(state), 32'h5);
        check("t1_pc", 32'(pc), 32'h4);
        check("t1_count", 32'(instr_count), 32'h4);
        check("t1_flags", 32'({flag_n, flag_z}), 32'h0);
        check("t1_store_seen", 32'(exp_q.size()), 32'h0);
        tick(5);
        check("t1_halt_absorbs", 32'(state), 32'h5);

        // Same program, 3 wait states per access
        hold_reset();
        mem[0] = 16'h002F; mem[1] = 16'h0054; mem[2] = 16'h0042; mem[3] = 16'h000C;
        exp_q.push_back('{addr: 8'h00, data: 16'h000A});
        release_reset(3, 1'b1);
        tick(14);
        check("t2_count_e14", 32'(instr_count), 32'h1);
        tick(1);
        check("t2_count_e15", 32'(instr_count), 32'h2);
        tick(14);
        check("t2_halted_e29", 32'(halted), 32'h0);
        tick(1);
        check("t2_halted_e30", 32'(halted), 32'h1);
        check("t2_pc", 32'(pc), 32'h4);
        check("t2_count", 32'(instr_count), 32'h4);
        check("t2_store_seen", 32'(exp_q.size()), 32'h0);

        // SUB R1,R1 ; BZ -2 loops forever
        hold_reset();
        mem[0] = 16'h0056; mem[1] = 16'h00EA;
        release_reset(0, 1'b1);
        tick(71);
        check("t3_count_e71", 32'(instr_count), 32'd20);
        check("t3_pc_e71", 32'(pc), 32'h0);
        check("t3_state_e71", 32'(state), 32'h1);
        check("t3_flag_z", 32'(flag_z), 32'h1);
        check("t3_flag_n", 32'(flag_n), 32'h0);
        tick(4);
        check("t3_count_e75", 32'(instr_count), 32'd21);
        check("t3_pc_e75", 32'(pc), 32'h1);

        // ORi 0x1F ; J -5 ; SHL R1,3 ; STORE ; HALT at 0xFF with PC wrap
        hold_reset();
        mem[0]     = 16'h00FF; mem[1]     = 16'h00B1;
        mem[8'hFD] = 16'h007B; mem[8'hFE] = 16'h0042; mem[8'hFF] = 16'h000C;
        exp_q.push_back('{addr: 8'h00, data: 16'h00F8});
        release_reset(0, 1'b1);
        tick(15);
        check("t4_fetch_pc_ff", 32'(pc), 32'hFF);
        check("t4_fetch_state", 32'(state), 32'h1);
        tick(1);
        check("t4_pc_wrap", 32'(pc), 32'h00);
        tick(2);
        check("t4_halted", 32'(halted), 32'h1);
        check("t4_count", 32'(instr_count), 32'd5);
        check("t4_flags", 32'({flag_n, flag_z}), 32'h0);
        check("t4_store_seen", 32'(exp_q.size()), 32'h0);

        // Single step with run low; a second pulse mid-instruction is ignored
        hold_reset();
        mem[0] = 16'h002F; mem[1] = 16'h0054;
        release_reset(0, 1'b0);
        tick(3);
        check("t5_idle_wait", 32'(state), 32'h0);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check("t5_fetch", 32'(state), 32'h1);
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(5);
        check("t5_state", 32'(state), 32'h0);
        check("t5_count", 32'(instr_count), 32'h1);
        check("t5_pc", 32'(pc), 32'h1);
        check("t5_ir", 32'(ir), 32'h2F);

        // Reset while the second fetch is stalled
        hold_reset();
        mem[0] = 16'h002F; mem[1] = 16'h0054;
        release_reset(3, 1'b1);
        tick(9);
        check("t6_pre_req", 32'(mem_req), 32'h1);
        check("t6_pre_pc", 32'(pc), 32'h1);
        check("t6_pre_ready", 32'(mem_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check("t6_req", 32'(mem_req), 32'h0);
        check("t6_state", 32'(state), 32'h0);
        check("t6_pc", 32'(pc), 32'h0);
        check("t6_count", 32'(instr_count), 32'h0);
        tick(3);
        check("t6_still_idle", 32'(state), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
